// File: rtl/delay_sweep_ctrl.sv
// Per-element delay sweep sequencer for the beamforming delay calculator.
// Walks every element per focal point and keeps a readable delay table.
module delay_sweep_ctrl #(
  parameter int          NUM_ELEM   = 8,
  parameter int          ADDR_W     = 3,
  parameter logic [15:0] ELEM_X0    = 16'd0,
  parameter logic [15:0] ELEM_PITCH = 16'd4,
  parameter logic [15:0] ELEM_Z     = 16'd0,
  parameter int          TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [15:0]       pt_x,
  input  logic [15:0]       pt_z,
  output logic              calc_start,
  output logic [15:0]       calc_x_i,
  output logic [15:0]       calc_x_f,
  output logic [15:0]       calc_z_i,
  output logic [15:0]       calc_z_f,
  input  logic [7:0]        calc_delay,
  input  logic              calc_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_delay,
  output logic [7:0]        rd_delay_rel,
  output logic [7:0]        min_delay,
  output logic              table_valid,
  output logic              frame_done,
  output logic              busy,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] elem_idx
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, STORE, NEXT, FINISH
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_ELEM - 1);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_E =
    (ADDR_W+1)'(NUM_ELEM);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       cap;
  logic             cap_to;
  logic [7:0]       run_min;
  logic             any_ok;
  logic [7:0]       tbl [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cap         <= '0;
      cap_to      <= 1'b0;
      run_min     <= 8'hFF;
      any_ok      <= 1'b0;
      pt_ready    <= 1'b0;
      calc_start  <= 1'b0;
      calc_x_i    <= '0;
      calc_x_f    <= '0;
      calc_z_i    <= '0;
      calc_z_f    <= '0;
      min_delay   <= '0;
      table_valid <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      elem_idx    <= '0;
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= '0;
    end else begin
      calc_start <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pt_valid && pt_ready) begin
            pt_ready    <= 1'b0;
            busy        <= 1'b1;
            calc_start  <= 1'b1;
            calc_x_f    <= pt_x;
            calc_z_f    <= pt_z;
            calc_x_i    <= ELEM_X0;
            calc_z_i    <= ELEM_Z;
            elem_idx    <= '0;
            run_min     <= 8'hFF;
            any_ok      <= 1'b0;
            timeout_err <= 1'b0;
            table_valid <= 1'b0;
            state       <= ISSUE;
          end else begin
            pt_ready <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // a done on the last allowed cycle still counts
          if (calc_done) begin
            cap    <= calc_delay;
            cap_to <= 1'b0;
            state  <= STORE;
          end else if (wait_cnt == CNT_MAX) begin
            cap         <= 8'hFF;
            cap_to      <= 1'b1;
            timeout_err <= 1'b1;
            state       <= STORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STORE: begin
          tbl[elem_idx] <= cap;
          if (!cap_to) begin
            any_ok <= 1'b1;
            if (cap < run_min)
              run_min <= cap;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (elem_idx == LAST) begin
            state       <= FINISH;
            frame_done  <= 1'b1;
            table_valid <= 1'b1;
            min_delay   <= any_ok ? run_min : 8'h00;
          end else begin
            elem_idx   <= elem_idx + 1'b1;
            calc_x_i   <= calc_x_i + ELEM_PITCH;
            calc_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        FINISH: begin
          busy     <= 1'b0;
          pt_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_delay     = '0;
    rd_delay_rel = '0;
    if ({1'b0, rd_addr} < NUM_E) begin
      rd_delay = tbl[rd_addr];
      if (rd_delay > min_delay)
        rd_delay_rel = rd_delay - min_delay;
    end
  end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Bench for delay_sweep_ctrl: calculator stub with scripted latency,
// directed frame table, queued-point, reset-in-WAIT and random frames.
module tb_delay_sweep_ctrl;

  localparam int NE = 8;
  localparam int AW = 4;
  localparam int TO = 64;
  localparam int NEVER = 100000;

  logic          clk;
  logic          reset;
  logic          pt_valid;
  logic          pt_ready;
  logic [15:0]   pt_x;
  logic [15:0]   pt_z;
  logic          calc_start;
  logic [15:0]   calc_x_i;
  logic [15:0]   calc_x_f;
  logic [15:0]   calc_z_i;
  logic [15:0]   calc_z_f;
  logic [7:0]    calc_delay;
  logic          calc_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_delay;
  logic [7:0]    rd_delay_rel;
  logic [7:0]    min_delay;
  logic          table_valid;
  logic          frame_done;
  logic          busy;
  logic          timeout_err;
  logic [AW-1:0] elem_idx;

  delay_sweep_ctrl #(
    .NUM_ELEM(NE), .ADDR_W(AW),
    .ELEM_X0(16'd0), .ELEM_PITCH(16'd4),
    .ELEM_Z(16'd0), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_z(pt_z),
    .calc_start(calc_start),
    .calc_x_i(calc_x_i), .calc_x_f(calc_x_f),
    .calc_z_i(calc_z_i), .calc_z_f(calc_z_f),
    .calc_delay(calc_delay), .calc_done(calc_done),
    .rd_addr(rd_addr), .rd_delay(rd_delay),
    .rd_delay_rel(rd_delay_rel),
    .min_delay(min_delay),
    .table_valid(table_valid),
    .frame_done(frame_done), .busy(busy),
    .timeout_err(timeout_err), .elem_idx(elem_idx)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int nvec;
  int nerr;

  int          stub_lat [NE];
  logic [7:0]  stub_dly [NE];
  int          sidx;
  int          pend;
  logic [7:0]  pdly;
  int          cyc;
  int          fd_cnt;
  int          st_cyc [NE];
  logic [15:0] st_x [NE];
  logic [15:0] st_xf [NE];
  logic [15:0] st_zi [NE];
  logic [15:0] st_zf [NE];

  typedef struct {
    logic [15:0] x;
    logic [15:0] z;
    int          lat [NE];
    logic [7:0]  dly [NE];
    int          exp_min;
    int          exp_terr;
  } frame_vec_t;

  frame_vec_t vec [4];

  task automatic chk(input string name,
                     input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // calculator stub: done arrives stub_lat cycles after start
  initial begin
    calc_done = 1'b0;
    calc_delay = 8'h00;
    pend = 0;
    cyc = 0;
    fd_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      calc_done = 1'b0;
      if (frame_done) fd_cnt++;
      if (reset) begin
        pend = 0;
      end else if (calc_start) begin
        if (sidx < NE) begin
          st_cyc[sidx] = cyc;
          st_x[sidx]   = calc_x_i;
          st_xf[sidx]  = calc_x_f;
          st_zi[sidx]  = calc_z_i;
          st_zf[sidx]  = calc_z_f;
          pend = stub_lat[sidx];
          pdly = stub_dly[sidx];
        end
        sidx++;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          calc_done  = 1'b1;
          calc_delay = pdly;
        end
      end
    end
  end

  task automatic check_zero_outs(input string tag);
    chk({tag, "_pt_ready"}, int'(pt_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_start"}, int'(calc_start), 0);
    chk({tag, "_x_i"}, int'(calc_x_i), 0);
    chk({tag, "_x_f"}, int'(calc_x_f), 0);
    chk({tag, "_z_f"}, int'(calc_z_f), 0);
    chk({tag, "_tv"}, int'(table_valid), 0);
    chk({tag, "_fd"}, int'(frame_done), 0);
    chk({tag, "_terr"}, int'(timeout_err), 0);
    chk({tag, "_min"}, int'(min_delay), 0);
    chk({tag, "_idx"}, int'(elem_idx), 0);
    for (int i = 0; i < NE; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("%s_tbl%0d", tag, i),
          int'(rd_delay), 0);
    end
  endtask

  // model: derive the expected table from the stub's script
  task automatic check_table(input string tag,
                             input int x, input int z);
    int  e [NE];
    int  em;
    bit  ok;
    bit  anyto;
    int  w;
    ok = 0;
    anyto = 0;
    em = 0;
    for (int i = 0; i < NE; i++) begin
      if (stub_lat[i] > TO) begin
        e[i] = 255;
        anyto = 1;
      end else begin
        e[i] = int'(stub_dly[i]);
        if (!ok || e[i] < em) em = e[i];
        ok = 1;
      end
    end
    chk({tag, "_tv"}, int'(table_valid), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_min"}, int'(min_delay), em);
    chk({tag, "_terr"}, int'(timeout_err), int'(anyto));
    chk({tag, "_starts"}, sidx, NE);
    for (int i = 0; i < NE; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("%s_abs%0d", tag, i),
          int'(rd_delay), e[i]);
      chk($sformatf("%s_rel%0d", tag, i),
          int'(rd_delay_rel), e[i] > em ? e[i] - em : 0);
      chk($sformatf("%s_xi%0d", tag, i),
          int'(st_x[i]), (i * 4) % 65536);
      chk($sformatf("%s_xf%0d", tag, i),
          int'(st_xf[i]), x);
      chk($sformatf("%s_zf%0d", tag, i),
          int'(st_zf[i]), z);
      chk($sformatf("%s_zi%0d", tag, i),
          int'(st_zi[i]), 0);
      if (i < NE - 1) begin
        w = stub_lat[i] > TO ? TO : stub_lat[i];
        chk($sformatf("%s_gap%0d", tag, i),
            st_cyc[i+1] - st_cyc[i], w + 3);
      end
    end
    rd_addr = AW'(9);
    #1;
    chk({tag, "_oob_abs"}, int'(rd_delay), 0);
    chk({tag, "_oob_rel"}, int'(rd_delay_rel), 0);
  endtask

  task automatic accept(input int x, input int z,
                        output bit ok);
    int n;
    sidx = 0;
    pt_valid = 1'b1;
    pt_x = 16'(x);
    pt_z = 16'(z);
    n = 0;
    while (!pt_ready && n < 20) begin
      step();
      n++;
    end
    ok = pt_ready;
    if (!ok) chk("accept_wait", 0, 1);
    step();
  endtask

  task automatic wait_done(input string tag,
                           output bit ok);
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin
      step();
      n++;
    end
    ok = frame_done;
    chk({tag, "_done_seen"}, int'(frame_done), 1);
  endtask

  task automatic run_frame(input string tag,
                           input int x, input int z);
    bit ok;
    int fd0;
    fd0 = fd_cnt;
    accept(x, z, ok);
    pt_valid = 1'b0;
    if (!ok) return;
    wait_done(tag, ok);
    if (!ok) return;
    check_table(tag, x, z);
    step();
    chk({tag, "_pulse"}, int'(frame_done), 0);
    chk({tag, "_npulse"}, fd_cnt - fd0, 1);
  endtask

  task automatic load_stub(input int v);
    for (int i = 0; i < NE; i++) begin
      stub_lat[i] = vec[v].lat[i];
      stub_dly[i] = vec[v].dly[i];
    end
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int bad;
    int n;
    int r;
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    pt_valid = 1'b0;
    pt_x = '0;
    pt_z = '0;
    rd_addr = '0;
    sidx = 0;
    repeat (3) step();
    check_zero_outs("rst");
    reset = 1'b0;
    step();
    chk("rst_ready", int'(pt_ready), 1);
    chk("rst_idle_busy", int'(busy), 0);

    vec[0].x = 16'd0;
    vec[0].z = 16'd10;
    vec[0].lat = '{1, 2, 3, 4, 5, 6, 7, 8};
    vec[0].dly = '{10, 10, 12, 15, 18, 22, 26, 29};
    vec[0].exp_min = 10;
    vec[0].exp_terr = 0;
    vec[1].x = 16'd3;
    vec[1].z = 16'd40;
    for (int i = 0; i < NE; i++) begin
      vec[1].lat[i] = NEVER;
      vec[1].dly[i] = 8'd5;
    end
    vec[1].exp_min = 0;
    vec[1].exp_terr = 1;
    vec[2].x = 16'd12;
    vec[2].z = 16'd7;
    vec[2].lat = '{2, 2, 2, 64, 2, 2, 2, 2};
    vec[2].dly = '{20, 21, 22, 7, 23, 24, 25, 26};
    vec[2].exp_min = 7;
    vec[2].exp_terr = 0;
    vec[3].x = 16'hFFFF;
    vec[3].z = 16'h8000;
    vec[3].lat = '{65, 2, 5, 1, 7, 3, 66, 4};
    vec[3].dly = '{40, 33, 50, 60, 45, 70, 8, 35};
    vec[3].exp_min = 33;
    vec[3].exp_terr = 1;

    for (int v = 0; v < 4; v++) begin
      load_stub(v);
      run_frame($sformatf("vec%0d", v),
                int'(vec[v].x), int'(vec[v].z));
      chk($sformatf("vec%0d_tmin", v),
          int'(min_delay), vec[v].exp_min);
      chk($sformatf("vec%0d_tterr", v),
          int'(timeout_err), vec[v].exp_terr);
    end

    // second point held on pt_valid throughout a sweep
    load_stub(0);
    accept(100, 50, ok);
    pt_x = 16'd200;
    pt_z = 16'd60;
    bad = 0;
    n = 0;
    while (!frame_done && n < 3000) begin
      if (pt_ready) bad++;
      step();
      n++;
    end
    chk("q_ready_low", bad, 0);
    chk("q_done1", int'(frame_done), 1);
    chk("q_fin_ready", int'(pt_ready), 0);
    check_table("q1", 100, 50);
    load_stub(2);
    sidx = 0;
    step();
    chk("q_idle_ready", int'(pt_ready), 1);
    step();
    pt_valid = 1'b0;
    chk("q_tv_drop", int'(table_valid), 0);
    chk("q_busy2", int'(busy), 1);
    chk("q_start2", int'(calc_start), 1);
    wait_done("q2", ok);
    if (ok) check_table("q2", 200, 60);
    step();

    // reset while waiting on element 5
    load_stub(0);
    stub_lat[5] = NEVER;
    accept(77, 88, ok);
    pt_valid = 1'b0;
    n = 0;
    while (sidx < 6 && n < 500) begin
      step();
      n++;
    end
    chk("r_reach5", sidx, 6);
    repeat (3) step();
    chk("r_idx5", int'(elem_idx), 5);
    chk("r_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    check_zero_outs("r");
    reset = 1'b0;
    step();
    chk("r_ready", int'(pt_ready), 1);
    stub_lat[5] = 3;
    run_frame("r_new", 9, 21);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NE; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) stub_lat[i] = NEVER;
        else if (r == 1)
          stub_lat[i] = int'($urandom_range(60, 66));
        else stub_lat[i] = int'($urandom_range(1, 8));
        stub_dly[i] = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", f),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/delay_sweep_ctrl.md
Name: delay_sweep_ctrl

Overview:
Initiator-side sequencer for the beamforming delay calculator. It accepts one focal point (x_f, z_f) per frame over a valid/ready handshake and walks every transducer element. For each element it drives the calculator's start/coordinate inputs, waits for its done pulse, and stores the returned delay in an internal per-element table. Downstream beamsum/apodization logic reads the finished table (absolute and min-relative delays) once table_valid is high.

Parameters:
NUM_ELEM, 8, number of transducer elements swept per focal point (>=2)
ADDR_W, 3, table address width; ceil(log2(NUM_ELEM))
ELEM_X0, 16'd0, x coordinate of element 0
ELEM_PITCH, 16'd4, x spacing between adjacent elements
ELEM_Z, 16'd0, z coordinate of all elements (linear array)
TIMEOUT, 64, max cycles to wait for calc_done per element

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pt_valid  in  1  focal point offered
pt_ready  out  1  block can accept a focal point
pt_x  in  16  focal x
pt_z  in  16  focal z
calc_start  out  1  one-cycle start pulse to calculator
calc_x_i  out  16  element x
calc_x_f  out  16  focal x (latched)
calc_z_i  out  16  element z
calc_z_f  out  16  focal z (latched)
calc_delay  in  8  calculator result, valid when calc_done=1
calc_done  in  1  calculator completion pulse
rd_addr  in  ADDR_W  table read address
rd_delay  out  8  table[rd_addr], combinational read
rd_delay_rel  out  8  table[rd_addr] - min_delay, combinational
min_delay  out  8  minimum delay of current frame
table_valid  out  1  table complete and stable
frame_done  out  1  one-cycle pulse when sweep completes
busy  out  1  sweep in progress
timeout_err  out  1  sticky: some element timed out this frame
elem_idx  out  ADDR_W  element currently being processed (debug)

Behaviour:
- Reset: all outputs 0, state IDLE, table entries 0, min_delay 8'hFF internally but min_delay output 0 until first frame_done; latched focal point 0. Reset mid-sweep aborts immediately; the calculator is reset by the same signal.
- States: IDLE, ISSUE, WAIT, STORE, NEXT, FINISH.
- IDLE: pt_ready=1. On pt_valid&pt_ready, latch pt_x/pt_z, elem_idx<=0, running min<=8'hFF, timeout_err<=0, table_valid<=0, go to ISSUE. pt_ready=0 in all other states.
- ISSUE: calc_start=1 for exactly this cycle; go to WAIT and clear the wait counter.
- WAIT: calc_x_i/x_f/z_i/z_f stay stable from ISSUE through STORE. On calc_done, capture calc_delay and go to STORE. If the counter reaches TIMEOUT-1 without calc_done, capture 8'hFF, set timeout_err, and go to STORE. If calc_done and timeout coincide, calc_done wins.
- STORE: table[elem_idx]<=captured value. Running min updates only from non-timeout entries.
- NEXT: if elem_idx==NUM_ELEM-1, go to FINISH; otherwise elem_idx+1 and go to ISSUE. This gives >=2 idle cycles between a calc_done and the next calc_start, which the calculator requires to return to its idle state.
- FINISH: min_delay<=running min (0 if every element timed out), table_valid<=1, frame_done=1 for one cycle, then IDLE.
- calc_x_i = ELEM_X0 + elem_idx*ELEM_PITCH, truncated mod 2^16, registered. calc_z_i = ELEM_Z.
- rd_delay_rel saturates at 0. Timed-out entries read 8'hFF absolute and 8'hFF-min relative.
- busy=1 in every state except IDLE.
- Latency per element = 1 (ISSUE) + calc latency + 1 (STORE) + 1 (NEXT). Frame adds 1 accept cycle and 1 FINISH cycle.
- rd_addr >= NUM_ELEM returns 0 on both read outputs.
- table_valid drops the cycle after a new point is accepted. The table is rewritten entry-by-entry during the sweep and must not be consumed then.

Test Plan:
- Defaults with real delay_calc, point (0,10): table = 10,10,12,15,18,22,26,29; min_delay=10; rel = 0,0,2,5,8,12,16,19; one frame_done pulse; timeout_err=0.
- Stub calculator that never asserts done, TIMEOUT=64: each element waits exactly 64 cycles. All entries read 8'hFF, timeout_err=1, min_delay=0, frame_done still asserted.
- pt_valid held high through a sweep with a second point queued: pt_ready stays 0 until IDLE. The second point is accepted the cycle after frame_done. table_valid falls and is reasserted with the new table.
- Stub asserts calc_done on the same cycle the timeout expires for element 3: table[3] = calc_delay, timeout_err stays 0.
- reset asserted during WAIT on element 5: next cycle all outputs 0, pt_ready=1 after reset release, table cleared. A new point then sweeps from element 0.
- Check calc_start spacing and calc_x_i sequence 0,4,8,...,28 against the bench. Check rd_addr=9 returns 0.
